// File: rtl/act_sparse_gather_unit_pkg.sv
// rtl/act_sparse_gather_unit_pkg.sv - shared defaults and gather state type for the sparse gather unit
package act_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_BLOCK_NUMBER = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    GATHER = 1'b1
  } gather_state_e;

endpackage

// File: rtl/act_sparse_gather_unit_if.sv
// rtl/act_sparse_gather_unit_if.sv - block-in / beat-out handshake bundle for the sparse gather unit
interface act_sparse_gather_unit_if
  import act_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int BLOCK_NUMBER = DEFAULT_BLOCK_NUMBER,
  localparam int IDX_WIDTH   = $clog2(BLOCK_NUMBER)
);

  logic                               in_valid;
  logic                               in_ready;
  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] Input_act_data;
  logic [BLOCK_NUMBER-1:0]            weight_mask;

  logic                               out_valid;
  logic                               out_ready;
  logic [DATA_WIDTH-1:0]              Output_act_data;
  logic [IDX_WIDTH-1:0]               Output_idx;
  logic                               Output_last;
  logic                               block_done;

  modport master (
    output in_valid, Input_act_data, weight_mask, out_ready,
    input  in_ready, out_valid, Output_act_data, Output_idx, Output_last, block_done
  );

  modport slave (
    input  in_valid, Input_act_data, weight_mask, out_ready,
    output in_ready, out_valid, Output_act_data, Output_idx, Output_last, block_done
  );

endinterface

// File: rtl/act_sparse_gather_unit_lsb_prio_enc.sv
// rtl/act_sparse_gather_unit_lsb_prio_enc.sv - combinational lowest-set-bit index and nonzero flag
module lsb_prio_enc
  import act_pkg::*;
#(
  parameter int WIDTH = DEFAULT_BLOCK_NUMBER,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             nonzero
);

  // Scan high to low so the lowest set bit is the last (winning) assignment.
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  assign nonzero = |vec;

endmodule

// File: rtl/act_sparse_gather_unit.sv
// rtl/act_sparse_gather_unit.sv - gathers activations at nonzero-weight positions, one beat per set bit
// Optional ACT_ZERO_SKIP_EN: also drop positions whose activation element is zero.
module act_sparse_gather_unit
  import act_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int BLOCK_NUMBER = DEFAULT_BLOCK_NUMBER,
  localparam int IDX_WIDTH   = $clog2(BLOCK_NUMBER)
) (
  input logic                   clk,
  input logic                   rst_n,
  act_sparse_gather_unit_if.slave bus
);

  gather_state_e                      state_q;
  gather_state_e                      state_d;
  logic [BLOCK_NUMBER-1:0]            pending_q;
  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] act_q;
  logic [BLOCK_NUMBER-1:0]            eff_mask;
  logic [BLOCK_NUMBER-1:0]            enc_onehot;
  logic [BLOCK_NUMBER-1:0]            pending_rest;
  logic [IDX_WIDTH-1:0]               enc_idx;
  logic                               enc_nz;

  logic                               out_valid_q;
  logic [DATA_WIDTH-1:0]              out_data_q;
  logic [IDX_WIDTH-1:0]               out_idx_q;
  logic                               out_last_q;
  logic                               block_done_q;

  logic                               capture;
  logic                               load;
  logic                               done_d;

`ifdef ACT_ZERO_SKIP_EN
  for (genvar g = 0; g < BLOCK_NUMBER; g++) begin : g_zero_skip
    assign eff_mask[g] = bus.weight_mask[g] & (|bus.Input_act_data[g*DATA_WIDTH +: DATA_WIDTH]);
  end
`else
  assign eff_mask = bus.weight_mask;
`endif

  lsb_prio_enc #(
    .WIDTH (BLOCK_NUMBER)
  ) u_enc (
    .vec     (pending_q),
    .idx     (enc_idx),
    .nonzero (enc_nz)
  );

  assign enc_onehot   = BLOCK_NUMBER'(1) << enc_idx;
  assign pending_rest = pending_q & ~enc_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An empty pending mask only ends the block once no beat is left in the output stage.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = GATHER;
        end
      end
      GATHER: begin
        load = enc_nz && (!out_valid_q || bus.out_ready);
        if (out_valid_q && bus.out_ready && out_last_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!out_valid_q && !enc_nz) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      act_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      block_done_q <= done_d;
      if (capture) begin
        pending_q <= eff_mask;
        act_q     <= bus.Input_act_data;
      end else if (load) begin
        pending_q <= pending_rest;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_data_q  <= act_q[enc_idx*DATA_WIDTH +: DATA_WIDTH];
        out_idx_q   <= enc_idx;
        out_last_q  <= ~|pending_rest;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready        = (state_q == IDLE);
  assign bus.out_valid       = out_valid_q;
  assign bus.Output_act_data = out_data_q;
  assign bus.Output_idx      = out_idx_q;
  assign bus.Output_last     = out_last_q;
  assign bus.block_done      = block_done_q;

endmodule

// File: tb/tb_act_sparse_gather_unit.sv
// tb/tb_act_sparse_gather_unit.sv - directed self-checking bench for act_sparse_gather_unit (honours ACT_ZERO_SKIP_EN)
module tb_act_sparse_gather_unit;

  typedef struct {
    int idx;
    int dat;
    int last;
  } beat_t;

  logic  clk;
  logic  rst_n;
  logic  toggle_en;
  int    n_cmp;
  int    n_bad;
  int    cyc;
  int    done_cnt;
  int    done_cyc;
  int    last_cyc;
  beat_t beat_q[$];
  beat_t exp_q[$];

  logic        stall_pend;
  logic [7:0]  stall_dat;
  logic [3:0]  stall_idx;
  logic        stall_last;

  act_sparse_gather_unit_if #(.DATA_WIDTH(8), .BLOCK_NUMBER(16)) bus ();
  act_sparse_gather_unit_if #(.DATA_WIDTH(16), .BLOCK_NUMBER(32)) bus32 ();

  act_sparse_gather_unit #(.DATA_WIDTH(8), .BLOCK_NUMBER(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  act_sparse_gather_unit #(.DATA_WIDTH(16), .BLOCK_NUMBER(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (toggle_en) bus.out_ready = ~bus.out_ready;
      else           bus.out_ready = 1'b1;
    end
  end

  // Records accepted beats, block_done pulses, and stall stability of the 16-lane unit.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.Output_act_data, stall_dat);
        check("stall_idx", bus.Output_idx, stall_idx);
        check("stall_last", bus.Output_last, stall_last);
      end
      stall_pend = bus.out_valid && !bus.out_ready;
      stall_dat  = bus.Output_act_data;
      stall_idx  = bus.Output_idx;
      stall_last = bus.Output_last;
      if (bus.out_valid && bus.out_ready) begin
        beat_q.push_back('{int'(bus.Output_idx), int'(bus.Output_act_data), int'(bus.Output_last)});
        if (bus.Output_last) last_cyc = cyc;
      end
      if (bus.block_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic exp_beat(input int i, input int d, input int l);
    exp_q.push_back('{i, d, l});
  endtask

  task automatic send(input logic [15:0] m, input logic [127:0] d);
    @(negedge clk);
    check("send_in_ready", bus.in_ready, 1);
    bus.in_valid       = 1'b1;
    bus.weight_mask    = m;
    bus.Input_act_data = d;
    @(posedge clk);
    #1;
    bus.in_valid       = 1'b0;
    bus.weight_mask    = '0;
    bus.Input_act_data = '0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt != start) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic drain_compare(input string tag);
    beat_t b;
    beat_t e;
    check({tag, "_count"}, beat_q.size(), exp_q.size());
    while (exp_q.size() > 0 && beat_q.size() > 0) begin
      b = beat_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_idx"}, b.idx, e.idx);
      check({tag, "_data"}, b.dat, e.dat);
      check({tag, "_last"}, b.last, e.last);
    end
    exp_q.delete();
    beat_q.delete();
  endtask

  initial begin
    logic [127:0] d;
    logic [511:0] d32;
    int           wait_k;

    n_cmp = 0; n_bad = 0; cyc = 0; done_cnt = 0; done_cyc = 0; last_cyc = 0;
    toggle_en = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.weight_mask = '0; bus.Input_act_data = '0;
    bus32.in_valid = 1'b0; bus32.weight_mask = '0; bus32.Input_act_data = '0;
    bus32.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_block_done", bus.block_done, 0);
    check("rst_idx", bus.Output_idx, 0);
    check("rst_data", bus.Output_act_data, 0);
    check("rst_last", bus.Output_last, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);

    // mask 0x8421, element i = i+1
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 1);
    send(16'h8421, d);
    @(negedge clk);
    check("lat_not_yet", bus.out_valid, 0);
    @(negedge clk);
    check("lat_valid", bus.out_valid, 1);
    check("lat_idx", bus.Output_idx, 0);
    wait_done(20);
    check("t1_done_gap", done_cyc - last_cyc, 1);
    exp_beat(0, 1, 0); exp_beat(5, 6, 0); exp_beat(10, 11, 0); exp_beat(15, 16, 1);
    drain_compare("t1");

    // mask 0xFFFF under toggling out_ready, with ignored in_valid mid-block
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i * 3 + 16);
    toggle_en = 1'b1;
    send(16'hFFFF, d);
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b1; bus.weight_mask = 16'h0003; bus.Input_act_data = {16{8'hEE}};
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0; bus.weight_mask = '0; bus.Input_act_data = '0;
    wait_done(200);
    toggle_en = 1'b0;
    check("t2_done_gap", done_cyc - last_cyc, 1);
    for (int i = 0; i < 16; i++) exp_beat(i, i * 3 + 16, (i == 15) ? 1 : 0);
    drain_compare("t2");
    repeat (5) @(negedge clk);
    check("t2_no_extra", beat_q.size(), 0);
    check("t2_in_ready", bus.in_ready, 1);

    // empty mask
    send(16'h0000, {16{8'h55}});
    @(negedge clk);
    check("t3_done_early", bus.block_done, 0);
    check("t3_busy", bus.in_ready, 0);
    @(negedge clk);
    check("t3_done", bus.block_done, 1);
    check("t3_in_ready", bus.in_ready, 1);
    check("t3_no_valid", bus.out_valid, 0);
    check("t3_beats", beat_q.size(), 0);

    // zero activations under mask 0x000F
    d = {16{8'hAA}};
    d[7:0] = 8'd0; d[15:8] = 8'd7; d[23:16] = 8'd0; d[31:24] = 8'd9;
    send(16'h000F, d);
    wait_done(20);
`ifdef ACT_ZERO_SKIP_EN
    exp_beat(1, 7, 0); exp_beat(3, 9, 1);
`else
    exp_beat(0, 0, 0); exp_beat(1, 7, 0); exp_beat(2, 0, 0); exp_beat(3, 9, 1);
`endif
    drain_compare("t4");

    // reset after the second beat of mask 0x00FF
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(32 + i);
    send(16'h00FF, d);
    wait_k = 0;
    while (beat_q.size() < 2 && wait_k < 20) begin
      @(negedge clk);
      #1;
      wait_k++;
    end
    if (beat_q.size() < 2) check("t5_beat_timeout", 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", bus.out_valid, 0);
    check("t5_rst_idx", bus.Output_idx, 0);
    check("t5_rst_last", bus.Output_last, 0);
    exp_beat(0, 32, 0); exp_beat(1, 33, 0);
    drain_compare("t5_pre");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_quiet", beat_q.size(), 0);
    check("t5_quiet_valid", bus.out_valid, 0);
    check("t5_in_ready", bus.in_ready, 1);
    d = '0; d[7:0] = 8'h5A;
    send(16'h0001, d);
    wait_done(20);
    exp_beat(0, 8'h5A, 1);
    drain_compare("t5_post");

    // 32-lane, 16-bit instance
    d32 = '0;
    d32[15:0]    = 16'h1234;
    d32[511:496] = 16'hBEEF;
    @(negedge clk);
    check("t6_in_ready", bus32.in_ready, 1);
    bus32.in_valid = 1'b1; bus32.weight_mask = 32'h8000_0001; bus32.Input_act_data = d32;
    @(posedge clk);
    #1;
    bus32.in_valid = 1'b0; bus32.weight_mask = '0; bus32.Input_act_data = '0;
    @(negedge clk);
    check("t6_lat", bus32.out_valid, 0);
    @(negedge clk);
    check("t6_b0_valid", bus32.out_valid, 1);
    check("t6_b0_idx", bus32.Output_idx, 0);
    check("t6_b0_data", bus32.Output_act_data, 16'h1234);
    check("t6_b0_last", bus32.Output_last, 0);
    @(negedge clk);
    check("t6_b1_valid", bus32.out_valid, 1);
    check("t6_b1_idx", bus32.Output_idx, 31);
    check("t6_b1_data", bus32.Output_act_data, 16'hBEEF);
    check("t6_b1_last", bus32.Output_last, 1);
    @(negedge clk);
    check("t6_done", bus32.block_done, 1);
    check("t6_drop", bus32.out_valid, 0);
    check("t6_in_ready", bus32.in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
